// File: rtl/vga_sprite_stage.sv
// Pixel-colour stage: draws a bouncing solid square over a white x==y diagonal.
// Two-stage pixel pipeline; syncs are delayed alongside the registered RGB.
module vga_sprite_stage #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x_in,
  input  logic [9:0]  y_in,
  input  logic        active_in,
  input  logic        hs_n_in,
  input  logic        vs_n_in,
  input  logic        move_en,
  input  logic [11:0] box_rgb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs_n,
  output logic        vga_vs_n,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y,
  output logic [7:0]  frame_cnt
);

  localparam logic [9:0]  X_MAX  = 10'(H_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  Y_MAX  = 10'(V_ACTIVE - BOX_SIZE);
  localparam logic [9:0]  STEP_V = 10'(STEP);
  localparam logic [10:0] BOX_V  = 11'(BOX_SIZE);

  logic        prev_vs_reg;
  logic [7:0]  frame_cnt_reg;
  logic        tick;
  logic [1:0]  in_range;

  logic        s1_active_reg;
  logic        s1_hs_n_reg;
  logic        s1_vs_n_reg;
  logic        s1_in_box_reg;
  logic        s1_diag_reg;

  logic [11:0] rgb_reg;
  logic        hs_n_reg;
  logic        vs_n_reg;

  // Falling edge of vsync marks the frame tick, inside vertical blanking.
  assign tick = prev_vs_reg && !vs_n_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_vs_reg   <= 1'b1;
      frame_cnt_reg <= '0;
    end else begin
      prev_vs_reg <= vs_n_in;
      if (tick) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  // Axis 0 is horizontal, axis 1 vertical; each bounces independently.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      localparam logic [9:0] LIMIT = (gi == 0) ? X_MAX : Y_MAX;
      logic [9:0]  pos_reg;
      logic        dir_neg_reg;
      logic [9:0]  coord;
      logic [10:0] fwd_sum;

      assign coord        = (gi == 0) ? x_in : y_in;
      assign fwd_sum      = {1'b0, pos_reg} + {1'b0, STEP_V};
      assign in_range[gi] = (coord >= pos_reg) &&
                            ({1'b0, coord} < ({1'b0, pos_reg} + BOX_V));

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pos_reg     <= '0;
          dir_neg_reg <= 1'b0;
        end else if (tick && move_en) begin
          if (!dir_neg_reg) begin
            if (fwd_sum >= {1'b0, LIMIT}) begin
              pos_reg     <= LIMIT;
              dir_neg_reg <= 1'b1;
            end else begin
              pos_reg <= fwd_sum[9:0];
            end
          end else begin
            if (pos_reg <= STEP_V) begin
              pos_reg     <= '0;
              dir_neg_reg <= 1'b0;
            end else begin
              pos_reg <= pos_reg - STEP_V;
            end
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_active_reg <= 1'b0;
      s1_hs_n_reg   <= 1'b1;
      s1_vs_n_reg   <= 1'b1;
      s1_in_box_reg <= 1'b0;
      s1_diag_reg   <= 1'b0;
    end else begin
      s1_active_reg <= active_in;
      s1_hs_n_reg   <= hs_n_in;
      s1_vs_n_reg   <= vs_n_in;
      s1_in_box_reg <= &in_range;
      s1_diag_reg   <= (x_in == y_in);
    end
  end

  // The square wins over the diagonal; box_rgb is taken live at this stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_reg  <= '0;
      hs_n_reg <= 1'b1;
      vs_n_reg <= 1'b1;
    end else begin
      hs_n_reg <= s1_hs_n_reg;
      vs_n_reg <= s1_vs_n_reg;
      if (!s1_active_reg) begin
        rgb_reg <= 12'h000;
      end else if (s1_in_box_reg) begin
        rgb_reg <= box_rgb;
      end else if (s1_diag_reg) begin
        rgb_reg <= 12'hFFF;
      end else begin
        rgb_reg <= 12'h000;
      end
    end
  end

  assign vga_r     = rgb_reg[11:8];
  assign vga_g     = rgb_reg[7:4];
  assign vga_b     = rgb_reg[3:0];
  assign vga_hs_n  = hs_n_reg;
  assign vga_vs_n  = vs_n_reg;
  assign box_x     = g_axis[0].pos_reg;
  assign box_y     = g_axis[1].pos_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_vga_sprite_stage.sv
// Bench for vga_sprite_stage: triangle-wave position model plus per-cycle output compare,
// with literal checks for reset, latency, rendering, bouncing and mid-frame reset.
module tb_vga_sprite_stage;

  localparam int X_MAX = 608;
  localparam int Y_MAX = 448;
  localparam int H_TOT = 100;
  localparam int V_TOT = 60;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x_in = '0;
  logic [9:0]  y_in = '0;
  logic        active_in = 1'b0;
  logic        hs_n_in = 1'b1;
  logic        vs_n_in = 1'b1;
  logic        move_en = 1'b0;
  logic [11:0] box_rgb = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs_n, vga_vs_n;
  logic [9:0]  box_x, box_y;
  logic [7:0]  frame_cnt;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  always #20 clk = ~clk;

  vga_sprite_stage dut (
    .clk(clk), .rst_n(rst_n), .x_in(x_in), .y_in(y_in), .active_in(active_in),
    .hs_n_in(hs_n_in), .vs_n_in(vs_n_in), .move_en(move_en), .box_rgb(box_rgb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs_n(vga_hs_n), .vga_vs_n(vga_vs_n),
    .box_x(box_x), .box_y(box_y), .frame_cnt(frame_cnt)
  );

  // ---------------- behavioural model ----------------
  typedef struct {
    int x; int y; bit act; bit hs; bit vs; int bx; int by;
  } pix_t;

  int          move_ticks = 0;
  int          frames = 0;
  bit          prev_vs = 1'b1;
  bit          model_valid = 1'b0;
  pix_t        s1;
  logic [11:0] exp_rgb = '0;
  bit          exp_hs = 1'b1;
  bit          exp_vs = 1'b1;

  // With a step of one, the bounce is a triangle wave of period 2*lim in move ticks.
  function automatic int tri_pos(int k, int lim);
    int m;
    m = k % (2 * lim);
    return (m <= lim) ? m : 2 * lim - m;
  endfunction

  function automatic logic [11:0] colour(pix_t p, logic [11:0] rgb);
    if (!p.act) return 12'h000;
    if (p.x >= p.bx && p.x < p.bx + 32 && p.y >= p.by && p.y < p.by + 32) return rgb;
    if (p.x == p.y) return 12'hFFF;
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    cycle++;
    if (!rst_n) begin
      move_ticks = 0;
      frames     = 0;
      prev_vs    = 1'b1;
      s1         = '{x: 0, y: 0, act: 1'b0, hs: 1'b1, vs: 1'b1, bx: 0, by: 0};
      exp_rgb    = 12'h000;
      exp_hs     = 1'b1;
      exp_vs     = 1'b1;
      model_valid = 1'b1;
    end else begin
      exp_rgb = colour(s1, box_rgb);
      exp_hs  = s1.hs;
      exp_vs  = s1.vs;
      s1 = '{x: int'(x_in), y: int'(y_in), act: active_in, hs: hs_n_in, vs: vs_n_in,
             bx: tri_pos(move_ticks, X_MAX), by: tri_pos(move_ticks, Y_MAX)};
      if (prev_vs && !vs_n_in) begin
        frames++;
        if (move_en) move_ticks++;
      end
      prev_vs = vs_n_in;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      checks++;
      if ({vga_r, vga_g, vga_b} !== exp_rgb || vga_hs_n !== exp_hs || vga_vs_n !== exp_vs ||
          box_x !== 10'(tri_pos(move_ticks, X_MAX)) || box_y !== 10'(tri_pos(move_ticks, Y_MAX)) ||
          frame_cnt !== 8'(frames)) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model cycle %0d: rgb=%h/%h hs=%b/%b vs=%b/%b box=(%0d,%0d)/(%0d,%0d) frame=%0d/%0d",
                   cycle, {vga_r, vga_g, vga_b}, exp_rgb, vga_hs_n, exp_hs, vga_vs_n, exp_vs,
                   box_x, box_y, tri_pos(move_ticks, X_MAX), tri_pos(move_ticks, Y_MAX),
                   frame_cnt, frames & 255);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end else begin
      $display("ok   %s = %0d (0x%0h)", name, act, act);
    end
  endtask

  task automatic tick();
    vs_n_in = 1'b0;
    @(negedge clk);
    vs_n_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic pix(string name, int x, int y, bit act, int exp);
    x_in = 10'(x); y_in = 10'(y); active_in = act;
    repeat (2) @(negedge clk);
    chk(name, int'({vga_r, vga_g, vga_b}), exp);
  endtask

  int h = 0;
  int v = 0;
  task automatic gen_step();
    x_in      = 10'(h);
    y_in      = 10'(v);
    active_in = (h < 80) && (v < 48);
    hs_n_in   = !(h >= 85 && h < 95);
    vs_n_in   = !(v >= 50 && v < 52);
    h++;
    if (h == H_TOT) begin h = 0; v = (v + 1) % V_TOT; end
    @(negedge clk);
  endtask

  initial begin
    // Reset with arbitrary inputs.
    repeat (3) begin
      x_in = 10'($urandom); y_in = 10'($urandom); active_in = 1'($urandom);
      hs_n_in = 1'($urandom); vs_n_in = 1'($urandom); move_en = 1'($urandom);
      box_rgb = 12'($urandom);
      @(negedge clk);
    end
    chk("reset_rgb", int'({vga_r, vga_g, vga_b}), 0);
    chk("reset_hs", int'(vga_hs_n), 1);
    chk("reset_vs", int'(vga_vs_n), 1);
    chk("reset_box_x", int'(box_x), 0);
    chk("reset_box_y", int'(box_y), 0);
    chk("reset_frame", int'(frame_cnt), 0);

    // Latency and sync alignment.
    x_in = 0; y_in = 0; active_in = 0; hs_n_in = 1; vs_n_in = 1; move_en = 0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    x_in = 40; y_in = 40; active_in = 1; hs_n_in = 0;
    @(negedge clk);
    hs_n_in = 1;
    chk("lat_hs_plus1", int'(vga_hs_n), 1);
    @(negedge clk);
    chk("lat_hs_plus2", int'(vga_hs_n), 0);
    chk("lat_rgb_plus2", int'({vga_r, vga_g, vga_b}), 12'hFFF);
    @(negedge clk);
    chk("lat_hs_plus3", int'(vga_hs_n), 1);

    // Box rendering at (0,0).
    box_rgb = 12'hF00;
    pix("box_31_31", 31, 31, 1, 12'hF00);
    pix("box_32_0", 32, 0, 1, 12'h000);
    pix("box_0_32", 0, 32, 1, 12'h000);
    pix("box_over_diag", 5, 5, 1, 12'hF00);
    box_rgb = 12'h0F0;
    @(negedge clk);
    chk("box_rgb_live", int'({vga_r, vga_g, vga_b}), 12'h0F0);
    pix("box_inactive", 5, 5, 0, 12'h000);
    pix("diag_outside", 100, 100, 1, 12'hFFF);

    // Motion and bounces.
    active_in = 0; move_en = 1;
    repeat (448) tick();
    chk("mv448_x", int'(box_x), 448);
    chk("mv448_y", int'(box_y), 448);
    chk("mv448_frame", int'(frame_cnt), 192);
    tick();
    chk("mv449_x", int'(box_x), 449);
    chk("mv449_y_flip", int'(box_y), 447);
    repeat (157) tick();
    chk("mv606_x", int'(box_x), 606);
    tick();
    chk("mv607_x", int'(box_x), 607);
    tick();
    chk("mv608_x", int'(box_x), 608);
    tick();
    chk("mv609_x_flip", int'(box_x), 607);
    chk("mv609_y", int'(box_y), 287);
    chk("mv609_frame", int'(frame_cnt), 97);

    // Freeze: ticks count but position holds.
    move_en = 0;
    repeat (5) tick();
    chk("freeze_x", int'(box_x), 607);
    chk("freeze_y", int'(box_y), 287);
    chk("freeze_frame", int'(frame_cnt), 102);

    // Randomized traffic biased toward the square.
    repeat (3000) begin
      int bx, by;
      bx = tri_pos(move_ticks, X_MAX);
      by = tri_pos(move_ticks, Y_MAX);
      move_en   = ($urandom_range(0, 3) != 0);
      vs_n_in   = ($urandom_range(0, 5) != 0);
      hs_n_in   = 1'($urandom);
      active_in = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) box_rgb = 12'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        x_in = 10'(bx + $urandom_range(0, 40) - 4);
        y_in = 10'(by + $urandom_range(0, 40) - 4);
      end else begin
        x_in = 10'($urandom);
        y_in = ($urandom_range(0, 3) == 0) ? x_in : 10'($urandom);
      end
      @(negedge clk);
    end

    // Mid-frame reset under a small-frame timing generator.
    move_en = 1; box_rgb = 12'h00F;
    h = 0; v = 0;
    repeat (20 * H_TOT + 37) gen_step();
    rst_n = 1'b0;
    repeat (3) gen_step();
    rst_n = 1'b1;
    repeat (2 * H_TOT * V_TOT) gen_step();
    chk("midreset_x", int'(box_x), 2);
    chk("midreset_y", int'(box_y), 2);
    chk("midreset_frame", int'(frame_cnt), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sprite_stage.md
# vga_sprite_stage

Pixel-colour stage feeding the VGA pins, directly downstream of the VGA timing generator. It consumes the generator's pixel coordinates, display-enable and active-low syncs, all on the 25 MHz pixel clock. It draws a solid square that bounces off the screen edges one step per frame, over a white x==y diagonal on a black background. It outputs registered 4-bit RGB with syncs delayed to match.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- BOX_SIZE, 32, square edge in pixels (1..V_ACTIVE)
- STEP, 1, pixels moved per frame on each axis (1..15)
- clk  in  1  pixel clock (25 MHz); all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- x_in  in  10  current pixel column from timing generator
- y_in  in  10  current pixel row from timing generator
- active_in  in  1  display-enable, high inside 640x480 area
- hs_n_in  in  1  horizontal sync, active-low
- vs_n_in  in  1  vertical sync, active-low
- move_en  in  1  1 = square moves on frame tick; 0 = frozen
- box_rgb  in  12  square colour {R[11:8],G[7:4],B[3:0]}
- vga_r, vga_g, vga_b  out  4 each  pixel colour
- vga_hs_n, vga_vs_n  out  1 each  syncs, delayed to align with RGB
- box_x, box_y  out  10 each  current top-left corner of square
- frame_cnt  out  8  frame tick counter

## Operation
- X_MAX = H_ACTIVE-BOX_SIZE (608 at defaults), Y_MAX = V_ACTIVE-BOX_SIZE (448).
- Frame tick: cycle where registered previous vs_n_in = 1 and current vs_n_in = 0 (falling edge, start of vertical sync, inside blanking).
- frame_cnt increments on every tick, independent of move_en; 255 wraps to 0.
- On tick with move_en=1, each axis updates independently (x shown; y identical with Y_MAX, dir_y):
  - dir_x=+: if box_x+STEP >= X_MAX then box_x<=X_MAX, dir_x<=-; else box_x<=box_x+STEP.
  - dir_x=-: if box_x <= STEP then box_x<=0, dir_x<=+; else box_x<=box_x-STEP.
- Corner hit: both directions flip on the same tick.
- Position registers change only on tick, so no mid-frame tearing.
- Pixel pipeline, 2 stages:
  - S1 registers x, y, active, hs_n, vs_n.
  - S1 computes in_box = (x>=box_x)&&(x<box_x+BOX_SIZE)&&(y>=box_y)&&(y<box_y+BOX_SIZE), using 11-bit sums, and diag = (x==y).
  - S2 colour priority: !active -> 0x000; in_box -> box_rgb; diag -> 0xFFF; else 0x000.
  - S2 forwards hs_n, vs_n unchanged.
- Reset (rst_n=0 at a clock edge, any time including mid-line or mid-frame):
  - box_x=0, box_y=0, dir_x=+, dir_y=+, frame_cnt=0.
  - Both pipeline stages cleared: active=0, hs_n=1, vs_n=1, RGB=0.
  - Previous-vs register = 1, so a low vs_n_in on the first post-reset cycle counts as a tick.

## Timing
- Latency: x/y/active/syncs at cycle N -> vga_* at N+2; syncs and RGB stay exactly aligned.
- Outputs during reset and the first 2 cycles after release: vga_r/g/b=0, vga_hs_n=1, vga_vs_n=1.
- box_x/box_y/frame_cnt update the cycle after the tick edge is detected, i.e. visible at N+1 for a falling edge at N.
- box_rgb is sampled at S2, with no extra delay; changes take effect on the pixel then in S2.
- No backpressure; one pixel accepted and one produced every cycle.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with arbitrary inputs -> RGB=0, hs_n=vs_n=1, box_x=box_y=0, frame_cnt=0.
- Latency/alignment: drive x=40,y=40,active=1, hs_n pulse low for one cycle -> RGB=0xFFF and vga_hs_n low exactly 2 cycles later.
- Box render: box at (0,0), box_rgb=0xF00 -> x=31,y=31 gives 0xF00; x=32,y=0 gives 0x000; x=5,y=5 gives 0xF00 (box beats diagonal); active=0 at x=5,y=5 gives 0x000.
- Motion/bounce: force box_x=606, dir_x=+, STEP=1, 3 vs_n falling edges -> box_x 607, 608 (dir flips), 607; frame_cnt +3.
- Corner and freeze: box_x=608, box_y=448, both dir + -> one tick gives (608,448) with both dirs -; second tick gives (607,447). With move_en=0, 5 ticks leave position unchanged and frame_cnt +5.
- Mid-frame reset: assert rst_n=0 while box at (300,200), then run 2 full 800x525 frames -> position (2,2), frame_cnt=2, no RGB outside active area.
